// File: rtl/wb_slave_pkg.sv
// rtl/wb_slave_pkg.sv - shared state encoding and sizing helper for the Wishbone burst slave
package wb_slave_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} wb_slv_state_t;

  // Width of a counter that must hold the larger of the two latencies.
  function automatic int lat_width(input int first, input int beat);
    int m;
    m = (first > beat) ? first : beat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wb_sram_bytewise.sv
// rtl/wb_sram_bytewise.sv - single-port RAM with per-byte write enables and a registered read port
module wb_sram_bytewise #(
  parameter int DWIDTH = 32,
  parameter int SWIDTH = DWIDTH / 8,
  parameter int WORDS  = 1024,
  parameter int AW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [SWIDTH-1:0] sel,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < SWIDTH; b++) begin
        if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_burst_mem_slave.sv
// rtl/wb_burst_mem_slave.sv - Wishbone classic memory slave with programmable wait states, burst fast path and bus error
module wb_burst_mem_slave
  import wb_slave_pkg::*;
#(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = WB_DWIDTH / 8,
  parameter int MEM_WORDS = 1024,
  parameter int FIRST_LAT = 3,
  parameter int BEAT_LAT  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  output logic                 o_wb_ack,
  output logic                 o_wb_err
);

  localparam int CW = lat_width(FIRST_LAT, BEAT_LAT);
  localparam int BW = $clog2(WB_SWIDTH);
  localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  wb_slv_state_t        state, state_next;
  logic [CW-1:0]        cnt, cnt_next, lat_load;
  logic [31:0]          adr_q, last_adr, word_idx, cur_adr;
  logic [MW-1:0]        idx_q, cur_idx;
  logic [WB_DWIDTH-1:0] dat_q, cur_dat;
  logic [WB_SWIDTH-1:0] sel_q, cur_sel;
  logic                 we_q, cur_we, seq_valid;
  logic                 idle, req, in_range, seq_hit, to_ack, err_next;

  assign idle     = (state == S_IDLE);
  assign req      = i_wb_cyc & i_wb_stb;
  assign word_idx = i_wb_adr >> BW;
  assign in_range = (word_idx < 32'(MEM_WORDS));
  assign seq_hit  = seq_valid && (i_wb_adr == last_adr + 32'(WB_SWIDTH));
  assign lat_load = seq_hit ? CW'(BEAT_LAT) : CW'(FIRST_LAT);
  assign err_next = idle && req && !in_range;

  // A zero-latency beat completes on its sampling edge, so in S_IDLE the live bus feeds the memory.
  assign cur_adr = idle ? i_wb_adr : adr_q;
  assign cur_idx = idle ? word_idx[MW-1:0] : idx_q;
  assign cur_dat = idle ? i_wb_dat : dat_q;
  assign cur_sel = idle ? i_wb_sel : sel_q;
  assign cur_we  = idle ? i_wb_we : we_q;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    to_ack     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && in_range) begin
          cnt_next = lat_load;
          if (lat_load == '0) begin
            state_next = S_ACK;
            to_ack     = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_next = S_ACK;
            to_ack     = 1'b1;
          end
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      adr_q <= '0;
      idx_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else if (idle && req) begin
      adr_q <= i_wb_adr;
      idx_q <= word_idx[MW-1:0];
      dat_q <= i_wb_dat;
      sel_q <= i_wb_sel;
      we_q  <= i_wb_we;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_err  <= 1'b0;
      seq_valid <= 1'b0;
      last_adr  <= '0;
    end else begin
      o_wb_err <= err_next;
      if (!i_wb_cyc || err_next) begin
        seq_valid <= 1'b0;
      end else if (to_ack) begin
        seq_valid <= 1'b1;
        last_adr  <= cur_adr;
      end
    end
  end

  assign o_wb_ack = (state == S_ACK);

  wb_sram_bytewise #(
    .DWIDTH (WB_DWIDTH),
    .SWIDTH (WB_SWIDTH),
    .WORDS  (MEM_WORDS),
    .AW     (MW)
  ) u_sram (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (to_ack && cur_we),
    .re    (to_ack && !cur_we),
    .addr  (cur_idx),
    .sel   (cur_sel),
    .wdata (cur_dat),
    .rdata (o_wb_dat)
  );

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// tb/tb_wb_burst_mem_slave.sv - scoreboard bench for wb_burst_mem_slave with directed and random beats
module tb_wb_burst_mem_slave;

  localparam int MEM_WORDS = 1024;
  localparam int FIRST_LAT = 3;
  localparam int BEAT_LAT  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [31:0] wdat = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdat;
  logic        ack, err;

  wb_burst_mem_slave #(
    .WB_DWIDTH (32),
    .WB_SWIDTH (4),
    .MEM_WORDS (MEM_WORDS),
    .FIRST_LAT (FIRST_LAT),
    .BEAT_LAT  (BEAT_LAT)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_adr (adr),
    .i_wb_sel (sel),
    .i_wb_we  (we),
    .i_wb_dat (wdat),
    .i_wb_cyc (cyc),
    .i_wb_stb (stb),
    .o_wb_dat (rdat),
    .o_wb_ack (ack),
    .o_wb_err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rd;
    bit          known;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  bit          ref_seq = 1'b0;
  logic [31:0] ref_last = '0;
  int          n_total = 0;
  int          n_pass = 0;
  int          cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every ack/err the DUT shows must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ack || err)) begin
      if (ack && err) chk("ack_with_err", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_is_err", err, e.err);
        chk("resp_cycle", cyc_cnt, e.cyc);
        if (e.rd && e.known && ack) chk("rd_data", rdat, e.data);
      end
    end
  end

  task automatic beat(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                      input bit keep, output int lat, output logic [31:0] rd);
    exp_t        e;
    int          n, idx, exp_lat;
    bit          got;
    logic [31:0] mask;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s;
    n = cyc_cnt + 1;
    idx = int'(a >> 2);
    e.err = ((a >> 2) >= 32'(MEM_WORDS));
    e.rd = !w; e.known = 1'b0; e.data = '0;
    if (e.err) begin
      exp_lat = 0;
      ref_seq = 1'b0;
    end else begin
      exp_lat = (ref_seq && a == ref_last + 32'd4) ? BEAT_LAT : FIRST_LAT;
      if (w) begin
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (ref_mem.exists(idx)) ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
        else if (s == 4'hF) ref_mem[idx] = d;
      end else if (ref_mem.exists(idx)) begin
        e.known = 1'b1;
        e.data = ref_mem[idx];
      end
      ref_seq = 1'b1;
      ref_last = a;
    end
    e.cyc = n + exp_lat;
    exp_q.push_back(e);
    got = 1'b0; lat = -1; rd = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack || err) begin
        got = 1'b1;
        lat = cyc_cnt - n;
        rd = rdat;
      end
    end
    stb = 1'b0;
    if (!keep) begin
      cyc = 1'b0;
      ref_seq = 1'b0;
    end
    if (!got) chk("beat_timeout", 0, 1);
  endtask

  task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
    int acks = 0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; ref_seq = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = a; we = 1'b1; wdat = d; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rdv, old30, a;
    int          lat, r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", rdat, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      beat(32'(i) << 2, 1'b1, $urandom | 32'd1, 4'hF, 1'(i % 2), lat, rdv);

    // Single write then read, long latency
    beat(32'h10, 1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, lat, rdv);
    chk("t1_wr_lat", lat, 3);
    beat(32'h10, 1'b0, 32'h0, 4'hF, 1'b0, lat, rdv);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_dat", rdv, 32'hA5A5A5A5);

    // Four-beat read burst
    for (int k = 0; k < 4; k++) begin
      beat(32'h20 + 32'(4 * k), 1'b0, 32'h0, 4'hF, k < 3, lat, rdv);
      chk("t2_burst_lat", lat, (k == 0) ? 3 : 0);
    end

    // Byte lane write
    beat(32'h18, 1'b1, 32'h11223344, 4'hF, 1'b0, lat, rdv);
    beat(32'h18, 1'b1, 32'h0000BB00, 4'b0010, 1'b0, lat, rdv);
    beat(32'h18, 1'b0, 32'h0, 4'hF, 1'b0, lat, rdv);
    chk("t3_byte_merge", rdv, 32'h1122BB44);

    // Out of range error clears sequential tracking
    beat(32'h0, 1'b0, 32'h0, 4'hF, 1'b1, lat, rdv);
    beat(32'(MEM_WORDS * 4), 1'b0, 32'h0, 4'hF, 1'b1, lat, rdv);
    chk("t4_err_lat", lat, 0);
    beat(32'h4, 1'b0, 32'h0, 4'hF, 1'b0, lat, rdv);
    chk("t4_after_err_lat", lat, 3);

    // Aborted write leaves memory untouched
    beat(32'h14, 1'b1, 32'h01020304, 4'hF, 1'b0, lat, rdv);
    abort_write(32'h14, 32'hDEADBEEF);
    beat(32'h14, 1'b0, 32'h0, 4'hF, 1'b0, lat, rdv);
    chk("t5_abort_old", rdv, 32'h01020304);

    // Reset while waiting mid-burst
    old30 = ref_mem[12];
    beat(32'h20, 1'b0, 32'h0, 4'hF, 1'b1, lat, rdv);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h30; we = 1'b1; wdat = 32'hCAFEF00D; sel = 4'hF;
    @(posedge clk); #3;
    rst_n = 1'b0; stb = 1'b0; ref_seq = 1'b0;
    #1;
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_dat", rdat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'h24, 1'b0, 32'h0, 4'hF, 1'b1, lat, rdv);
    chk("t6_after_rst_lat", lat, 3);
    beat(32'h30, 1'b0, 32'h0, 4'hF, 1'b0, lat, rdv);
    chk("t6_no_write", rdv, old30);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        abort_write(32'($urandom_range(0, 15)) << 2, $urandom);
      end else if (r == 1) begin
        beat(32'(MEM_WORDS * 4) + (32'($urandom_range(0, 255)) << 2), 1'b0, 32'h0, 4'hF,
             1'($urandom_range(0, 1)), lat, rdv);
      end else if (r == 2) begin
        @(posedge clk); #1;
        cyc = 1'b0; ref_seq = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end else begin
        if (ref_seq && $urandom_range(0, 1) == 1) a = ref_last + 32'd4;
        else a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) begin
          @(posedge clk); #1;
        end
        beat(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, lat, rdv);
      end
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
